// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared mode constants and FSM encoding for the CPU step controller
//
// Purpose : mode codes presented on the board mode switches and the
//           execution-controller state encoding.
package cpu_dbg_pkg;

  localparam logic [1:0] MODE_STEP = 2'd0;  // one instruction per press
  localparam logic [1:0] MODE_RUN  = 2'd1;  // free run until the next press
  localparam logic [1:0] MODE_RUNN = 2'd2;  // run n_steps instructions
  localparam logic [1:0] MODE_BRK  = 2'd3;  // run until pc == bp_addr

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - button synchroniser, debouncer and press pulse generator
//
// Purpose : turns a raw asynchronous push button into a single-cycle press
//           pulse in the clk domain.
// Ports   : i_clk   system clock
//           i_rst   synchronous active-high reset
//           i_btn   raw button level
//           o_go    1-cycle pulse on an accepted 0->1 debounced transition
module step_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_go
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_go;

  logic w_diff;
  logic w_flip;

  assign w_diff = r_sync[1] ^ r_level;
  // The flipping sample is itself the DEBOUNCE_CYCLES-th consecutive differing sample.
  assign w_flip = w_diff & (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_go    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      // Pulse is registered on the same edge the level flips, rising only.
      r_go   <= w_flip & ~r_level;
      if (w_flip) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_go = r_go;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU execution controller producing a clock enable for the core
//
// Purpose : step / run / run-N / run-to-breakpoint control of a single-cycle
//           core via cpu_ce, with retired-instruction counting.
// Ports   : clk, rst        system clock, synchronous active-high reset
//           stp             raw step/run button
//           mode, n_steps   run mode and run-N count, taken on an accepted press
//           bp_en, bp_addr  live breakpoint enable and address
//           pc              current core PC
//           cpu_ce          core clock enable (combinational)
//           exec, halted    registered status
//           step_count      retired instructions since reset, wrapping
module cpu_step_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W            = 32,
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stp,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             exec,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  state_t           r_state;
  logic [1:0]       r_mode_q;
  logic [CNT_W-1:0] r_remaining;
  logic             r_first;
  logic [CNT_W-1:0] r_step_count;
  logic             r_exec;
  logic             r_halted;

  state_t w_state_nxt;
  logic   w_go;
  logic   w_hit;
  logic   w_brk_stop;
  logic   w_ce;
  logic   w_start;

  step_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .i_clk (clk),
    .i_rst (rst),
    .i_btn (stp),
    .o_go  (w_go)
  );

  // first masks the hit on the opening RUN cycle so a resume executes the breakpoint PC.
  assign w_hit      = bp_en & (pc == bp_addr) & ~r_first;
  assign w_brk_stop = (r_mode_q == MODE_BRK) & w_hit;
  assign w_start    = ((r_state == ST_IDLE) | (r_state == ST_HALT)) & w_go;

  always_comb begin
    w_state_nxt = r_state;
    w_ce        = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (w_go) begin
          // The live mode is used here; r_mode_q captures it on the same edge.
          case (mode)
            MODE_STEP: w_state_nxt = ST_STEP;
            MODE_RUNN: w_state_nxt = (n_steps == '0) ? ST_HALT : ST_RUN;
            default:   w_state_nxt = ST_RUN;
          endcase
        end
      end
      ST_STEP: begin
        w_ce        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        w_ce = ~w_brk_stop;
        if (w_go) begin
          w_state_nxt = ST_IDLE;
        end else if ((r_mode_q == MODE_RUNN) && (r_remaining == CNT_W'(1))) begin
          w_state_nxt = ST_HALT;
        end else if (w_brk_stop) begin
          w_state_nxt = ST_HALT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mode_q     <= MODE_STEP;
      r_remaining  <= '0;
      r_first      <= 1'b0;
      r_step_count <= '0;
      r_exec       <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_exec   <= (w_state_nxt == ST_STEP) | (w_state_nxt == ST_RUN);
      r_halted <= (w_state_nxt == ST_HALT);
      if (w_ce) begin
        r_step_count <= r_step_count + 1'b1;
      end
      if (w_start) begin
        r_mode_q    <= mode;
        r_remaining <= n_steps;
        r_first     <= 1'b1;
      end else if (r_state == ST_RUN) begin
        r_first <= 1'b0;
        if (w_ce) begin
          r_remaining <= r_remaining - 1'b1;
        end
      end
    end
  end

  assign cpu_ce     = w_ce;
  assign exec       = r_exec;
  assign halted     = r_halted;
  assign step_count = r_step_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - directed self-checking bench for cpu_step_ctrl
module tb_cpu_step_ctrl;

  localparam int PC_W  = 32;
  localparam int CNT_W = 4;
  localparam int DEB   = 4;

  logic             clk;
  logic             rst;
  logic             stp;
  logic [1:0]       mode;
  logic [CNT_W-1:0] n_steps;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             cpu_ce;
  logic             exec;
  logic             halted;
  logic [CNT_W-1:0] step_count;

  int asserts;
  int fails;
  int cyc;
  int ce_cnt;
  int ce_first;
  int ex_cnt;

  cpu_step_ctrl #(
    .PC_W(PC_W),
    .CNT_W(CNT_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stp        (stp),
    .mode       (mode),
    .n_steps    (n_steps),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_ce     (cpu_ce),
    .exec       (exec),
    .halted     (halted),
    .step_count (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core PC model: advances by 4 per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else if (cpu_ce) pc <= pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cpu_ce) begin
      ce_cnt++;
      if (ce_first < 0) ce_first = cyc;
    end
    if (exec) ex_cnt++;
  endtask

  task automatic clr();
    cyc      = 0;
    ce_cnt   = 0;
    ce_first = -1;
    ex_cnt   = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    clr();
  endtask

  task automatic press(input int hold, input int rel);
    stp = 1'b1;
    repeat (hold) tick();
    stp = 1'b0;
    repeat (rel) tick();
  endtask

  initial begin
    asserts  = 0;
    fails    = 0;
    rst      = 1'b1;
    stp      = 1'b0;
    mode     = 2'd0;
    n_steps  = '0;
    bp_en    = 1'b0;
    bp_addr  = '0;
    clr();
    tick();
    tick();
    chk("reset_ce", {63'd0, cpu_ce}, 64'd0);
    chk("reset_exec", {63'd0, exec}, 64'd0);
    chk("reset_halted", {63'd0, halted}, 64'd0);
    chk("reset_count", {60'd0, step_count}, 64'd0);
    rst = 1'b0;
    clr();

    // Single step: press at cycle 0, cpu_ce expected only in cycle 7.
    mode = 2'd0;
    press(20, 10);
    chk("step_first_ce", 64'(ce_first), 64'd7);
    chk("step_ce_count", 64'(ce_cnt), 64'd1);
    chk("step_exec_cycles", 64'(ex_cnt), 64'd1);
    chk("step_count", {60'd0, step_count}, 64'd1);
    chk("step_pc", {32'd0, pc}, 64'd4);

    // Bounce rejection: 2-cycle pulses never reach 4 stable samples.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      stp = ~stp;
      repeat (2) tick();
    end
    stp = 1'b0;
    repeat (12) tick();
    chk("bounce_ce", 64'(ce_cnt), 64'd0);
    chk("bounce_count", {60'd0, step_count}, 64'd0);

    // Run-N with 5; mode/n_steps changed mid-run must be ignored.
    do_reset();
    mode    = 2'd2;
    n_steps = 4'd5;
    stp     = 1'b1;
    repeat (8) tick();
    mode    = 2'd1;
    n_steps = 4'd9;
    repeat (2) tick();
    stp = 1'b0;
    repeat (10) tick();
    chk("runn_first_ce", 64'(ce_first), 64'd7);
    chk("runn_ce_count", 64'(ce_cnt), 64'd5);
    chk("runn_halted", {63'd0, halted}, 64'd1);
    chk("runn_exec", {63'd0, exec}, 64'd0);
    chk("runn_count", {60'd0, step_count}, 64'd5);
    chk("runn_pc", {32'd0, pc}, 64'd20);

    // Run-N with 0: straight to HALT with no enable.
    do_reset();
    mode    = 2'd2;
    n_steps = 4'd0;
    press(10, 10);
    chk("run0_ce_count", 64'(ce_cnt), 64'd0);
    chk("run0_halted", {63'd0, halted}, 64'd1);
    chk("run0_count", {60'd0, step_count}, 64'd0);

    // Run-to-break at 0xC: executes pc 0,4,8 then stops with pc=0xC.
    do_reset();
    mode    = 2'd3;
    bp_en   = 1'b1;
    bp_addr = 32'h0000_000C;
    press(10, 10);
    chk("brk_ce_count", 64'(ce_cnt), 64'd3);
    chk("brk_pc", {32'd0, pc}, 64'h0C);
    chk("brk_ce_at_bp", {63'd0, cpu_ce}, 64'd0);
    chk("brk_halted", {63'd0, halted}, 64'd1);
    chk("brk_count", {60'd0, step_count}, 64'd3);

    // Resume from the breakpoint PC: 0xC executes, run continues.
    clr();
    stp = 1'b1;
    repeat (10) tick();
    chk("resume_ce_count", 64'(ce_cnt), 64'd4);
    chk("resume_pc", {32'd0, pc}, 64'h18);
    chk("resume_exec", {63'd0, exec}, 64'd1);
    chk("resume_halted", {63'd0, halted}, 64'd0);
    stp = 1'b0;
    bp_en = 1'b0;

    // Free run, stopped by a second press: enable in cycles 7..22.
    do_reset();
    mode = 2'd1;
    press(10, 6);
    press(10, 8);
    chk("free_ce_count", 64'(ce_cnt), 64'd16);
    chk("free_pc", {32'd0, pc}, 64'd64);
    chk("free_exec", {63'd0, exec}, 64'd0);
    chk("free_halted", {63'd0, halted}, 64'd0);
    chk("free_count_wrap", {60'd0, step_count}, 64'd0);

    // Restart then reset mid-run.
    press(10, 2);
    chk("rerun_exec", {63'd0, exec}, 64'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_ce", {63'd0, cpu_ce}, 64'd0);
    chk("rst_mid_count", {60'd0, step_count}, 64'd0);
    chk("rst_mid_exec", {63'd0, exec}, 64'd0);
    rst = 1'b0;
    clr();

    // Counter wrap: 17 single steps on a 4-bit counter.
    do_reset();
    mode = 2'd0;
    for (int i = 0; i < 17; i++) begin
      press(8, 8);
    end
    chk("wrap_ce_count", 64'(ce_cnt), 64'd17);
    chk("wrap_count", {60'd0, step_count}, 64'd1);
    chk("wrap_pc", {32'd0, pc}, 64'd68);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
